// File: rtl/tft_defs.sv
// ============================================================================
// Module      : tft_defs (package)
// Description : Shared TFT video-path constants: colours, pipeline latency,
//               sprite mode encodings and the per-pixel control record.
// Revision    : 1.0 - initial sprite overlay support
// ============================================================================
`default_nettype none

package tft_defs;

    localparam logic [23:0] c_black   = 24'h000000;
    localparam logic [23:0] c_white   = 24'hFFFFFF;
    localparam logic [23:0] c_red     = 24'hFF0000;
    localparam logic [23:0] c_green   = 24'h00FF00;
    localparam logic [23:0] c_blue    = 24'h0000FF;
    localparam logic [23:0] c_yellow  = 24'hFFFF00;
    localparam logic [23:0] c_cyan    = 24'h00FFFF;
    localparam logic [23:0] c_magenta = 24'hFF00FF;

    // Clocks from pix_x/pix_y to rgb_data; the timing generator pre-advances by this.
    localparam int c_latency = 3;

    localparam logic [1:0] c_mode_off    = 2'b00;
    localparam logic [1:0] c_mode_steady = 2'b01;
    localparam logic [1:0] c_mode_blink  = 2'b10;
    localparam logic [1:0] c_mode_invert = 2'b11;

    typedef struct packed {
        logic in_win;
        logic vs;
        logic show;
        logic inv;
    } pix_ctl_t;

endpackage

`default_nettype wire

// File: rtl/sprite_rom.sv
// ============================================================================
// Module      : sprite_rom
// Description : Synchronous single-port 1-bit bitmap ROM with registered q.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_rom #(
    parameter string ROM_INIT = "sprite.mif",
    parameter int    DEPTH    = 20000,
    parameter int    BMP_W    = 200,
    parameter int    ADDR_W   = 15
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_q
);

    // Image is generated from the address; "solid" selects an all-ones bitmap,
    // any other name the checkerboard bring-up image.
    localparam logic        c_solid   = (ROM_INIT == "solid");
    localparam int unsigned c_depth_u = DEPTH;
    localparam int unsigned c_bmp_w_u = BMP_W;

    logic r_q;

    function automatic logic image_bit(input logic [ADDR_W-1:0] a);
        int unsigned v;
        v = 32'(a);
        if (v >= c_depth_u) return 1'b0;
        if (c_solid) return 1'b1;
        return (((v % c_bmp_w_u) + (v / c_bmp_w_u)) % 2) == 0;
    endfunction

    always_ff @(posedge clk) begin
        r_q <= image_bit(i_addr);
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/sprite_overlay.sv
// ============================================================================
// Module      : sprite_overlay
// Description : Scaled 1-bit sprite renderer with steady/blink/invert modes,
//               three-stage pipeline from pixel coordinates to RGB888.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_overlay
    import tft_defs::*;
#(
    parameter int          X0           = 220,
    parameter int          Y0           = 190,
    parameter int          BMP_W        = 200,
    parameter int          BMP_H        = 100,
    parameter int          SCALE_LOG2   = 0,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] FG           = 24'hFFFFFF,
    parameter logic [23:0] BG           = 24'h000000,
    parameter string       ROM_INIT     = "sprite.mif"
) (
    input  logic        tft_clk_9m,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        vsync,
    input  logic [1:0]  mode,
    output logic [23:0] rgb_data,
    output logic        rgb_valid
);

    localparam int          c_scale     = 1 << SCALE_LOG2;
    localparam int          c_depth     = BMP_W * BMP_H;
    localparam int          c_addr_w    = (c_depth > 1) ? $clog2(c_depth) : 1;
    localparam logic [11:0] c_x_lo      = 12'(X0);
    localparam logic [11:0] c_x_hi      = 12'(X0 + BMP_W * c_scale);
    localparam logic [11:0] c_x_last    = 12'(X0 + BMP_W * c_scale - 1);
    localparam logic [11:0] c_y_lo      = 12'(Y0);
    localparam logic [11:0] c_y_hi      = 12'(Y0 + BMP_H * c_scale);
    localparam logic [9:0]  c_sub_mask  = 10'(c_scale - 1);
    localparam logic [c_addr_w-1:0] c_row_step = c_addr_w'(BMP_W);
    localparam logic [7:0]  c_blink_last = 8'(BLINK_FRAMES - 1);

    localparam logic [0:0]  c_st_show   = 1'b0;
    localparam logic [0:0]  c_st_hide   = 1'b1;

    logic                r_vsync_d;
    logic                w_frame_start;
    logic [1:0]          r_mode_q;
    logic [1:0]          w_mode_nxt;
    logic [0:0]          r_blink_state;
    logic [0:0]          w_blink_state_nxt;
    logic [7:0]          r_blink_cnt;
    logic [7:0]          w_blink_cnt_nxt;

    logic [11:0]         w_px;
    logic [11:0]         w_py;
    logic                w_in_win;
    logic [9:0]          w_dx;
    logic [9:0]          w_dy;
    logic                w_row_last;
    logic [c_addr_w-1:0] r_row_base;
    logic [c_addr_w-1:0] w_row_base_cur;
    logic [c_addr_w-1:0] w_addr;

    pix_ctl_t            w_ctl;
    pix_ctl_t            r_s0_ctl;
    pix_ctl_t            r_s1_ctl;
    logic [c_addr_w-1:0] r_s0_addr;
    logic                w_rom_q;
    logic                w_s1_visible;
    logic [23:0]         r_rgb;
    logic                r_valid;

    assign w_frame_start = vsync & ~r_vsync_d;

    // Reset loads 1 so a reset taken mid-frame cannot fake a frame-start edge.
    always_ff @(posedge tft_clk_9m) begin
        if (sys_rst) begin
            r_vsync_d <= 1'b1;
        end else begin
            r_vsync_d <= vsync;
        end
    end

    // ---------------- address generator ----------------
    assign w_px       = {2'b00, pix_x};
    assign w_py       = {2'b00, pix_y};
    assign w_in_win   = (w_px >= c_x_lo) && (w_px < c_x_hi) &&
                        (w_py >= c_y_lo) && (w_py < c_y_hi);
    assign w_dx       = pix_x - 10'(X0);
    assign w_dy       = pix_y - 10'(Y0);
    assign w_row_last = ((w_dy & c_sub_mask) == c_sub_mask);

    assign w_row_base_cur = w_frame_start ? '0 : r_row_base;
    assign w_addr         = w_row_base_cur + c_addr_w'(w_dx >> SCALE_LOG2);

    // Bitmap row advances once per S screen lines, on the last window column.
    always_ff @(posedge tft_clk_9m) begin
        if (sys_rst || !vsync || w_frame_start) begin
            r_row_base <= '0;
        end else if (w_in_win && (w_px == c_x_last) && w_row_last) begin
            r_row_base <= r_row_base + c_row_step;
        end
    end

    // ---------------- mode / blink state machine ----------------
    always_ff @(posedge tft_clk_9m) begin
        if (sys_rst) begin
            r_mode_q      <= c_mode_off;
            r_blink_state <= c_st_show;
            r_blink_cnt   <= '0;
        end else begin
            r_mode_q      <= w_mode_nxt;
            r_blink_state <= w_blink_state_nxt;
            r_blink_cnt   <= w_blink_cnt_nxt;
        end
    end

    always_comb begin
        w_mode_nxt        = r_mode_q;
        w_blink_state_nxt = r_blink_state;
        w_blink_cnt_nxt   = r_blink_cnt;
        if (w_frame_start) begin
            w_mode_nxt = mode;
            if ((mode == c_mode_blink) && (r_mode_q == c_mode_blink)) begin
                if (r_blink_cnt == c_blink_last) begin
                    w_blink_cnt_nxt   = '0;
                    w_blink_state_nxt = (r_blink_state == c_st_show) ? c_st_hide : c_st_show;
                end else begin
                    w_blink_cnt_nxt = r_blink_cnt + 8'd1;
                end
            end else begin
                w_blink_state_nxt = c_st_show;
                w_blink_cnt_nxt   = '0;
            end
        end
    end

    // Next-state values already hold the new frame's mode/state on its first pixel.
    always_comb begin
        w_ctl        = '0;
        w_ctl.in_win = w_in_win;
        w_ctl.vs     = vsync;
        w_ctl.show   = (w_mode_nxt != c_mode_off) && (w_blink_state_nxt == c_st_show);
        w_ctl.inv    = (w_mode_nxt == c_mode_invert);
    end

    // ---------------- pipeline ----------------
    always_ff @(posedge tft_clk_9m) begin
        if (sys_rst) begin
            r_s0_ctl  <= '0;
            r_s0_addr <= '0;
            r_s1_ctl  <= '0;
        end else begin
            r_s0_ctl  <= w_ctl;
            r_s0_addr <= w_addr;
            r_s1_ctl  <= r_s0_ctl;
        end
    end

    sprite_rom #(
        .ROM_INIT (ROM_INIT),
        .DEPTH    (c_depth),
        .BMP_W    (BMP_W),
        .ADDR_W   (c_addr_w)
    ) u_rom (
        .clk    (tft_clk_9m),
        .i_addr (r_s0_addr),
        .o_q    (w_rom_q)
    );

    assign w_s1_visible = r_s1_ctl.in_win & r_s1_ctl.vs & r_s1_ctl.show;

    always_ff @(posedge tft_clk_9m) begin
        if (sys_rst) begin
            r_rgb   <= c_black;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_s1_visible;
            if (!w_s1_visible) begin
                r_rgb <= c_black;
            end else if (w_rom_q ^ r_s1_ctl.inv) begin
                r_rgb <= FG;
            end else begin
                r_rgb <= BG;
            end
        end
    end

    assign rgb_data  = r_rgb;
    assign rgb_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_sprite_overlay.sv
// ============================================================================
// Module      : tb_sprite_overlay
// Description : Randomised raster bench for two sprite_overlay instances
//               (scale 1 and scale 2) with a queue-based scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sprite_overlay;
    import tft_defs::*;

    typedef struct packed {
        logic [23:0] rgb;
        logic        vld;
    } exp_t;

    localparam int c_x0 = 220;
    localparam int c_y0 = 190;
    localparam int c_w  [2] = '{8, 4};
    localparam int c_h  [2] = '{4, 2};
    localparam int c_sl [2] = '{0, 1};
    localparam int c_bf [2] = '{2, 3};
    localparam logic [23:0] c_fg [2] = '{24'hFFFFFF, 24'h123456};
    localparam logic [23:0] c_bg [2] = '{24'h000000, 24'hA0B0C0};
    localparam exp_t c_blank = '{rgb: 24'h0, vld: 1'b0};

    logic        clk;
    logic        sys_rst;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        vsync;
    logic [1:0]  mode;
    logic [23:0] rgb [2];
    logic        vld [2];

    exp_t        sb [2][$];
    logic [1:0]  m_mode [2];
    int          m_idx  [2];
    logic        m_prev_vs;
    logic        rst_req;
    logic [1:0]  mode_req;
    int          n_vec;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sprite_overlay #(
        .X0(c_x0), .Y0(c_y0), .BMP_W(8), .BMP_H(4), .SCALE_LOG2(0),
        .BLINK_FRAMES(2), .FG(24'hFFFFFF), .BG(24'h000000), .ROM_INIT("sprite.mif")
    ) u_dut0 (
        .tft_clk_9m(clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
        .vsync(vsync), .mode(mode), .rgb_data(rgb[0]), .rgb_valid(vld[0])
    );

    sprite_overlay #(
        .X0(c_x0), .Y0(c_y0), .BMP_W(4), .BMP_H(2), .SCALE_LOG2(1),
        .BLINK_FRAMES(3), .FG(24'h123456), .BG(24'hA0B0C0), .ROM_INIT("sprite.mif")
    ) u_dut1 (
        .tft_clk_9m(clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
        .vsync(vsync), .mode(mode), .rgb_data(rgb[1]), .rgb_valid(vld[1])
    );

    // Reference: checkerboard bitmap cell (col,row) -> 1 when col+row is even.
    function automatic exp_t expect_pix(input int k, input int x, input int y, input logic vs);
        exp_t e;
        int   s;
        int   col;
        int   row;
        logic on;
        logic b;
        e = c_blank;
        s = 1 << c_sl[k];
        on = (m_mode[k] == c_mode_steady) || (m_mode[k] == c_mode_invert) ||
             ((m_mode[k] == c_mode_blink) && (((m_idx[k] / c_bf[k]) % 2) == 0));
        if (vs && on && x >= c_x0 && x < c_x0 + c_w[k] * s &&
            y >= c_y0 && y < c_y0 + c_h[k] * s) begin
            col = (x - c_x0) / s;
            row = (y - c_y0) / s;
            b = ((col + row) % 2) == 0;
            if (m_mode[k] == c_mode_invert) b = ~b;
            e.rgb = b ? c_fg[k] : c_bg[k];
            e.vld = 1'b1;
        end
        return e;
    endfunction

    task automatic step(input int x, input int y, input logic vs);
        logic fs;
        int   n;
        @(posedge clk);
        #1;
        pix_x   = 10'(x);
        pix_y   = 10'(y);
        vsync   = vs;
        sys_rst = rst_req;
        mode    = mode_req;
        fs = vs && !m_prev_vs;
        m_prev_vs = vs;
        for (int k = 0; k < 2; k++) begin
            if (rst_req) begin
                // Reset also flushes the two pixels still inside the pipeline.
                n = sb[k].size();
                if (n >= 1) sb[k][n-1] = c_blank;
                if (n >= 2) sb[k][n-2] = c_blank;
                sb[k].push_back(c_blank);
                m_mode[k] = c_mode_off;
                m_idx[k]  = 0;
            end else begin
                if (fs) begin
                    if (mode_req == c_mode_blink && m_mode[k] == c_mode_blink) m_idx[k]++;
                    else m_idx[k] = 0;
                    m_mode[k] = mode_req;
                end
                sb[k].push_back(expect_pix(k, x, y, vs));
            end
        end
    endtask

    task automatic run_frame(input logic [1:0] m_start, input int chg_at,
                             input logic [1:0] m_chg, input int rst_at);
        int cyc;
        mode_req = m_start;
        for (int g = 0; g < 4; g++) step(0, 0, 1'b0);
        cyc = 0;
        for (int y = 186; y < 200; y++) begin
            for (int x = 216; x < 232; x++) begin
                if (cyc == chg_at) mode_req = m_chg;
                rst_req = (cyc == rst_at);
                step(x, y, 1'b1);
                cyc++;
            end
        end
        rst_req = 1'b0;
    endtask

    // Monitor: output seen in cycle n belongs to the pixel pushed three cycles earlier.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (sb[k].size() >= 4) begin
                    e = sb[k].pop_front();
                    n_vec++;
                    if (rgb[k] !== e.rgb || vld[k] !== e.vld) begin
                        n_bad++;
                        $display("FAIL pix dut%0d t=%0t got rgb=%06h valid=%0b want rgb=%06h valid=%0b",
                                 k, $time, rgb[k], vld[k], e.rgb, e.vld);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] m;
        logic [1:0] mc;
        int         chg;
        int         r;
        n_vec = 0;
        n_bad = 0;
        sys_rst = 1'b1;
        pix_x = '0;
        pix_y = '0;
        vsync = 1'b0;
        mode  = c_mode_off;
        m_prev_vs = 1'b0;
        mode_req  = c_mode_steady;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = c_mode_off;
            m_idx[k]  = 0;
        end
        rst_req = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 1'b0);
        rst_req = 1'b0;

        run_frame(c_mode_steady, -1, c_mode_steady, -1);
        run_frame(c_mode_steady, 100, c_mode_invert, -1);
        run_frame(c_mode_invert, -1, c_mode_invert, -1);
        for (int f = 0; f < 6; f++) run_frame(c_mode_blink, -1, c_mode_blink, -1);
        run_frame(c_mode_off, -1, c_mode_off, -1);
        run_frame(c_mode_steady, -1, c_mode_steady, 90);
        run_frame(c_mode_steady, -1, c_mode_steady, -1);

        for (int f = 0; f < 16; f++) begin
            m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) m = c_mode_blink;
            mc  = 2'($urandom_range(0, 3));
            chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 223)) : -1;
            r   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 223)) : -1;
            run_frame(m, chg, mc, r);
        end

        for (int i = 0; i < 6; i++) step(0, 0, 1'b0);
        @(negedge clk);
        #1;
        if (n_vec < 1000) begin
            n_bad++;
            $display("FAIL vec_count got %0d want >= 1000", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_overlay.md
# sprite_overlay

Parametrised 1-bit bitmap sprite renderer for the TFT video path. It places a monochrome bitmap, scaled by 1, 2 or 4, at a fixed window position on the active frame and maps each bit to programmable foreground/background RGB888 colours. It adds steady, blink and invert modes, plus a valid flag so a downstream mixer can layer several instances. It sits between the TFT timing generator (pix_x/pix_y/vsync) and the RGB output mux, replacing the per-screen fixed-position overlays.

## Interface
- X0, 220: left edge of window (first drawn pixel column)
- Y0, 190: top edge of window (first drawn pixel row)
- BMP_W, 200: bitmap width in ROM pixels
- BMP_H, 100: bitmap height in ROM pixels
- SCALE_LOG2, 0: replication factor 2^SCALE_LOG2 in each axis; legal values 0, 1, 2
- BLINK_FRAMES, 30: frames per blink half-period; legal range 1..255
- FG, 24'hFFFFFF: colour for ROM bit 1
- BG, 24'h000000: colour for ROM bit 0
- ROM_INIT, "sprite.mif": init file passed to the ROM sub-module
- tft_clk_9m  in  1  pixel clock, 9 MHz
- sys_rst  in  1  synchronous, active-high reset
- pix_x  in  10  current pixel X coordinate
- pix_y  in  10  current pixel Y coordinate
- vsync  in  1  high during the active frame; the rising edge marks frame start
- mode  in  2  00 off, 01 steady, 10 blink, 11 invert (FG and BG swapped)
- rgb_data  out  24  pixel colour; BLACK outside the window or when hidden
- rgb_valid  out  1  high when rgb_data is a sprite pixel

## Operation
- Window: X0 ≤ pix_x < X0+BMP_W·S and Y0 ≤ pix_y < Y0+BMP_H·S, where S = 2^SCALE_LOG2 and both bounds are inclusive/exclusive exactly as written.
- ROM address = row_base + ((pix_x−X0) >> SCALE_LOG2). The width is ⌈log2(BMP_W·BMP_H)⌉, and the address path contains no multiplier.
- row_base is cleared on the frame-start edge. It advances by BMP_W on the last window column of a line, only when ((pix_y−Y0) mod S) = S−1.
- Frame-start detect: vsync_d is a registered copy of vsync. A frame starts when vsync=1 and vsync_d=0.
- Mode handling:
  - mode is sampled into mode_q at frame start only.
  - A change of mode mid-frame takes effect on the next frame.
- Blink state machine, with states SHOW and HIDE:
  - In mode_q=10, a frame counter increments at each frame start.
  - When the counter reaches BLINK_FRAMES−1 it wraps to 0 and the state toggles.
  - Entering blink mode starts in SHOW with the counter at 0.
  - Any other mode forces SHOW and counter 0.
- Visible condition: in-window AND mode_q≠00 AND state=SHOW AND vsync=1. When visible, rgb_data = bit ? FG : BG, with FG and BG swapped when mode_q=11, and rgb_valid=1. Otherwise rgb_data=BLACK and rgb_valid=0.
- vsync=0: row_base is held at 0 and the outputs are BLACK with rgb_valid=0.
- Reset: all state is cleared.
  - rgb_data=24'h000000, rgb_valid=0, row_base=0, mode_q=00, counter=0, state=SHOW.
  - A reset applied mid-frame blanks the output until the next frame start. Mode is re-sampled there.

## Timing
- The pipeline has three stages:
  - S0 registers the address, in-window flag and vsync.
  - S1 is the ROM registered read.
  - S2 registers the colour mux.
- rgb_data/rgb_valid correspond to the pix_x/pix_y that were presented 3 clocks earlier. LATENCY=3 is exported for the timing generator to pre-advance coordinates.
- The in-window flag is delayed 2 stages to align with the ROM data.
- Frame start and a last-column row_base advance never coincide, because vsync is low between frames. If they do coincide, clear takes priority.
- The blink toggle takes effect from the first pixel of the frame that caused the wrap.

## Structure
- Colour constants (RED…BLACK), LATENCY, and mode encodings belong in the shared tft_defs package/include, alongside the existing colour defines.
- The sub-module is sprite_rom: a synchronous single-port ROM, 1-bit wide, with parameters ROM_INIT, DEPTH = BMP_W·BMP_H and a registered q.
- The top level contains the address generator, blink state machine, and output stage.

## Test plan
- Reset with mode=01, SCALE_LOG2=0, and a checkerboard ROM. Expected:
  - Outputs are BLACK/valid=0 during reset.
  - Pixel (220,190) yields FG=FFFFFF, 3 clocks later.
  - Pixel (221,190) yields BG.
  - Pixel (219,190) yields BLACK with valid=0.
- SCALE_LOG2=1 with BMP_W=4, BMP_H=2. Expected:
  - Addresses repeat each value twice per line.
  - row_base goes 0,0,4,4 across rows 190..193.
  - Row 198 is outside the window, giving valid=0.
- mode=10, BLINK_FRAMES=2. Expected:
  - Frames 0–1 are visible and frames 2–3 are hidden.
  - Frame 4 is visible again.
- Switch mode from 01 to 11 mid-frame. Expected:
  - The current frame stays steady.
  - The next frame shows swapped colours (bit 1 → 000000).
- Assert sys_rst for 1 clock mid-window. Expected:
  - The output is BLACK until the next vsync rising edge.
  - The first window pixel of that frame is correct at address 0.
- mode=00. Expected: rgb_valid=0 and rgb_data=000000 for the whole frame, including window pixels.
